// File: rtl/rom_bank.sv
// Byte-addressed word memory with a strobed write port and a pipelined read port.
// Bad writes and reads are flagged. Memory contents survive reset.
module rom_bank #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [31:0]   w_addr_i,
  input  logic [DW-1:0] w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic          ren,
  input  logic [31:0]   r_addr_i,
  output logic [DW-1:0] r_data_o,
  output logic          r_valid_o,
  output logic          r_err_o,
  output logic          w_err_o
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OB    = $clog2(NB);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  function automatic logic addr_bad(input logic [31:0] a);
    return ((a & 32'(NB - 1)) != '0) || ((a >> (AW + OB)) != '0);
  endfunction

  logic          w_bad, r_bad, w_do;
  logic [AW-1:0] w_idx, r_idx;
  logic [DW-1:0] rd_word;

  logic          w_err_d, w_err_q;
  logic          r_valid_d, r_valid_q;
  logic          r_err_d, r_err_q;
  logic [DW-1:0] r_data_d, r_data_q;

  // Read-side result feeding the output register (direct or via stage 1).
  logic          o_valid, o_err;
  logic [DW-1:0] o_data;

  always_comb begin
    w_bad   = addr_bad(w_addr_i);
    r_bad   = addr_bad(r_addr_i);
    w_idx   = w_addr_i[AW+OB-1:OB];
    r_idx   = r_addr_i[AW+OB-1:OB];
    w_do    = wen && !w_bad;
    w_err_d = wen && w_bad && (w_strb_i != '0);
    // Write-first: merge strobed lanes of a same-edge write into the read word.
    rd_word = mem[r_idx];
    for (int unsigned k = 0; k < NB; k++) begin
      if (w_do && w_strb_i[k] && (w_idx == r_idx)) begin
        rd_word[8*k +: 8] = w_data_i[8*k +: 8];
      end
    end
    if (r_bad) begin
      rd_word = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (w_strb_i[k]) begin
          mem[w_idx][8*k +: 8] <= w_data_i[8*k +: 8];
        end
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s1_valid_d, s1_valid_q;
    logic          s1_err_d, s1_err_q;
    logic [DW-1:0] s1_data_d, s1_data_q;

    always_comb begin
      s1_valid_d = ren;
      s1_err_d   = ren && r_bad;
      s1_data_d  = ren ? rd_word : s1_data_q;
      o_valid    = s1_valid_q;
      o_err      = s1_err_q;
      o_data     = s1_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_valid_q <= 1'b0;
        s1_err_q   <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_err_q   <= s1_err_d;
        s1_data_q  <= s1_data_d;
      end
    end
  end else begin : g_lat1
    always_comb begin
      o_valid = ren;
      o_err   = ren && r_bad;
      o_data  = rd_word;
    end
  end

  always_comb begin
    r_valid_d = o_valid;
    r_err_d   = o_valid && o_err;
    r_data_d  = o_valid ? o_data : r_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
      w_err_q   <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
      r_err_q   <= r_err_d;
      r_data_q  <= r_data_d;
      w_err_q   <= w_err_d;
    end
  end

  assign r_data_o  = r_data_q;
  assign r_valid_o = r_valid_q;
  assign r_err_o   = r_err_q;
  assign w_err_o   = w_err_q;

endmodule

// File: tb/tb_rom_bank.sv
// Drives one input stream into RD_LAT=1 and RD_LAT=2 instances and checks both
// against a word-array reference model.
module tb_rom_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        ren = 1'b0;
  logic [31:0] r_addr = '0;

  logic [31:0] r_data1, r_data2;
  logic        r_valid1, r_valid2, r_err1, r_err2, w_err1, w_err2;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  rom_bank #(.DW(32), .AW(12), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .wen(wen), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .ren(ren), .r_addr_i(r_addr), .r_data_o(r_data1),
    .r_valid_o(r_valid1), .r_err_o(r_err1), .w_err_o(w_err1)
  );

  rom_bank #(.DW(32), .AW(12), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .wen(wen), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .ren(ren), .r_addr_i(r_addr), .r_data_o(r_data2),
    .r_valid_o(r_valid2), .r_err_o(r_err2), .w_err_o(w_err2)
  );

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } res_t;

  logic [31:0] m [0:4095];
  res_t        f_prev, exp1, exp2;
  logic [31:0] hold1, hold2;
  logic        exp_werr;

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h4000);
  endfunction

  task automatic model_reset();
    f_prev   = '0;
    exp1     = '0;
    exp2     = '0;
    hold1    = '0;
    hold2    = '0;
    exp_werr = 1'b0;
  endtask

  // One clock: present inputs, take the edge, advance the model, settle 1 unit.
  task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic re, input logic [31:0] ra);
    res_t f;
    wen = we; w_addr = wa; w_data = wd; w_strb = ws;
    ren = re; r_addr = ra;
    @(posedge clk);
    exp_werr = we && bad(wa) && (ws != 4'h0);
    if (we && !bad(wa)) begin
      for (int k = 0; k < 4; k++) begin
        if (ws[k]) m[wa[13:2]][8*k +: 8] = wd[8*k +: 8];
      end
    end
    f.v = re;
    f.e = re && bad(ra);
    f.d = (re && !bad(ra)) ? m[ra[13:2]] : 32'h0;
    exp1.v = f.v; exp1.e = f.e; exp1.d = f.v ? f.d : hold1; hold1 = exp1.d;
    exp2.v = f_prev.v; exp2.e = f_prev.e; exp2.d = f_prev.v ? f_prev.d : hold2; hold2 = exp2.d;
    f_prev = f;
    #1;
    wen = 1'b0; ren = 1'b0; w_strb = 4'h0;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total_cnt++;
    if ({r_valid1, r_err1, w_err1, r_data1, r_valid2, r_err2, w_err2, r_data2} !== '0)
      $display("FAIL reset_outputs: got v1=%b e1=%b we1=%b d1=%h v2=%b e2=%b we2=%b d2=%h want all 0",
               r_valid1, r_err1, w_err1, r_data1, r_valid2, r_err2, w_err2, r_data2);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b0, 32'h0);
      total_cnt++;
      if (w_err1 !== 1'b0 || w_err2 !== 1'b0)
        $display("FAIL init_werr: got %b/%b want 0 at word %0d", w_err1, w_err2, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    cycle(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10);
    total_cnt++;
    if ({r_valid1, r_err1, r_data1} !== {1'b1, 1'b0, 32'hDEADBEEF} || r_valid2 !== 1'b0)
      $display("FAIL basic_read_lat1: got v=%b e=%b d=%h v2=%b want 1 0 deadbeef 0",
               r_valid1, r_err1, r_data1, r_valid2);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({r_valid2, r_err2, r_data2, r_valid1} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0})
      $display("FAIL basic_read_lat2: got v=%b e=%b d=%h v1=%b want 1 0 deadbeef 0",
               r_valid2, r_err2, r_data2, r_valid1);
    else pass_cnt++;

    cycle(1'b1, 32'h10, 32'h11223344, 4'h5, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10);
    total_cnt++;
    if (r_data1 !== 32'hDE22BE44 || r_valid1 !== 1'b1)
      $display("FAIL strobe_merge: got v=%b d=%h want 1 de22be44", r_valid1, r_data1);
    else pass_cnt++;

    cycle(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    total_cnt++;
    if (w_err1 !== 1'b1 || w_err2 !== 1'b1)
      $display("FAIL werr_pulse: got %b/%b want 1", w_err1, w_err2);
    else pass_cnt++;
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10);
    total_cnt++;
    if (w_err1 !== 1'b0 || r_data1 !== 32'hDE22BE44 || r_err1 !== 1'b0)
      $display("FAIL werr_no_write: got werr=%b d=%h e=%b want 0 de22be44 0", w_err1, r_data1, r_err1);
    else pass_cnt++;

    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4000);
    total_cnt++;
    if ({r_valid1, r_err1, r_data1} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL oor_read: got v=%b e=%b d=%h want 1 1 0", r_valid1, r_err1, r_data1);
    else pass_cnt++;

    cycle(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 32'h20);
    total_cnt++;
    if ({r_valid1, r_err1, r_data1} !== {1'b1, 1'b0, 32'hCAFEF00D})
      $display("FAIL write_first_lat1: got v=%b e=%b d=%h want 1 0 cafef00d", r_valid1, r_err1, r_data1);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({r_valid2, r_data2} !== {1'b1, 32'hCAFEF00D} || r_valid1 !== 1'b0 || r_data1 !== 32'hCAFEF00D)
      $display("FAIL write_first_lat2: got v2=%b d2=%h v1=%b d1=%h want 1 cafef00d 0 cafef00d",
               r_valid2, r_data2, r_valid1, r_data1);
    else pass_cnt++;
  endtask

  task automatic test_strb_zero();
    cycle(1'b1, 32'h13, 32'h12345678, 4'h0, 1'b0, 32'h0);
    total_cnt++;
    if (w_err1 !== 1'b0 || w_err2 !== 1'b0)
      $display("FAIL strb0_no_err: got %b/%b want 0", w_err1, w_err2);
    else pass_cnt++;
    cycle(1'b1, 32'h10, 32'h12345678, 4'h0, 1'b1, 32'h10);
    total_cnt++;
    if (r_data1 !== 32'hDE22BE44 || w_err1 !== 1'b0)
      $display("FAIL strb0_no_change: got d=%h werr=%b want de22be44 0", r_data1, w_err1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hA1A1A1A1; vals[2] = 32'hA2A2A2A2; vals[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), vals[i], 4'hF, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'(i * 4));
      else idle();
      total_cnt++;
      if (i == 0 || i == 5) begin
        if (r_valid2 !== 1'b0 || (i == 5 && r_data2 !== vals[3]))
          $display("FAIL burst_lat2_idle: step %0d got v=%b d=%h want 0 (hold a3a3a3a3 at end)", i, r_valid2, r_data2);
        else pass_cnt++;
      end else begin
        if ({r_valid2, r_err2, r_data2} !== {1'b1, 1'b0, vals[i-1]})
          $display("FAIL burst_lat2: step %0d got v=%b e=%b d=%h want 1 0 %h", i, r_valid2, r_err2, r_data2, vals[i-1]);
        else pass_cnt++;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned r;
    a = 32'($urandom_range(63)) << 2;
    r = $urandom_range(9);
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = a | (32'h1 << $urandom_range(14, 31));
    return a;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(1)), rand_addr(), $urandom, 4'($urandom_range(15)),
            1'($urandom_range(3) != 0), rand_addr());
      total_cnt++;
      if ({r_valid1, r_err1, r_data1, w_err1} !== {exp1.v, exp1.e, exp1.d, exp_werr})
        $display("FAIL random_lat1: cyc %0d got v=%b e=%b d=%h we=%b want v=%b e=%b d=%h we=%b",
                 i, r_valid1, r_err1, r_data1, w_err1, exp1.v, exp1.e, exp1.d, exp_werr);
      else pass_cnt++;
      total_cnt++;
      if ({r_valid2, r_err2, r_data2, w_err2} !== {exp2.v, exp2.e, exp2.d, exp_werr})
        $display("FAIL random_lat2: cyc %0d got v=%b e=%b d=%h we=%b want v=%b e=%b d=%h we=%b",
                 i, r_valid2, r_err2, r_data2, w_err2, exp2.v, exp2.e, exp2.d, exp_werr);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1'b1, 32'h30, 32'h5A5A1234, 4'hF, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h34);
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({r_valid1, r_err1, r_data1, r_valid2, r_err2, r_data2} !== '0)
      $display("FAIL reset_async_clear: got v1=%b d1=%h v2=%b d2=%h want 0", r_valid1, r_data1, r_valid2, r_data2);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      total_cnt++;
      if (r_valid1 !== 1'b0 || r_valid2 !== 1'b0)
        $display("FAIL reset_discard: step %0d got v1=%b v2=%b want 0", i, r_valid1, r_valid2);
      else pass_cnt++;
    end
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h30);
    total_cnt++;
    if ({r_valid1, r_data1} !== {1'b1, 32'h5A5A1234})
      $display("FAIL mem_kept_lat1: got v=%b d=%h want 1 5a5a1234", r_valid1, r_data1);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({r_valid2, r_data2} !== {1'b1, 32'h5A5A1234})
      $display("FAIL mem_kept_lat2: got v=%b d=%h want 1 5a5a1234", r_valid2, r_data2);
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_directed();
    test_strb_zero();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rom_bank.md
ROM_BANK -- requirements
Module: rom_bank

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter AW, default 12, word-address width; depth is 2**AW words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 Derived constants: NB = DW/8 byte lanes; OB = log2(NB) byte-offset bits.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 wen  in  1  write request, sampled on the rising edge.
REQ-008 w_addr_i  in  32  write byte address.
REQ-009 w_data_i  in  DW  write data.
REQ-010 w_strb_i  in  NB  byte-lane write enables; bit k covers data bits [8k+7:8k].
REQ-011 ren  in  1  read request, sampled on the rising edge.
REQ-012 r_addr_i  in  32  read byte address.
REQ-013 r_data_o  out  DW  read data, registered.
REQ-014 r_valid_o  out  1  one-cycle pulse marking new r_data_o.
REQ-015 r_err_o  out  1  qualifies r_valid_o: the read was misaligned or out of range.
REQ-016 w_err_o  out  1  one-cycle pulse: the write sampled on the previous edge was rejected.

Function
REQ-017 Word index SHALL be addr[AW+OB-1:OB].
REQ-018 An address is misaligned when addr[OB-1:0] != 0 (never when OB = 0).
REQ-019 An address is out of range when any bit addr[31:AW+OB] is 1.
REQ-020 A write with wen=1 and a legal address SHALL update exactly the strobed byte lanes on the same edge; unstrobed lanes are kept.
REQ-021 A write with an illegal address SHALL not modify memory, and w_err_o SHALL be 1 for exactly the following cycle.
REQ-022 wen=1 with w_strb_i=0 SHALL be legal, SHALL modify nothing and SHALL NOT raise w_err_o.
REQ-023 A read sampled at edge N SHALL produce r_valid_o=1 in the cycle after edge N+RD_LAT-1.
REQ-024 That read's data SHALL appear on r_data_o in the same cycle as its r_valid_o.
REQ-025 Read throughput SHALL be one read per cycle for both RD_LAT values, with no bubbles.
REQ-026 An illegal read SHALL return r_data_o = 0 with r_err_o = 1, at the normal read latency.
REQ-027 A legal read SHALL return r_err_o = 0.
REQ-028 Simultaneous read and write to the same legal word on one edge SHALL be write-first: the read returns the old word with the strobed lanes replaced by w_data_i.
REQ-029 When no read completes in a cycle, r_valid_o and r_err_o SHALL be 0, and r_data_o SHALL hold its last value.
REQ-030 For RD_LAT = 2, the valid and error flags SHALL be pipelined alongside the data; the stage-2 register updates only when stage 1 holds a valid read.
REQ-031 Write-first forwarding (REQ-028) SHALL apply to memory state at the sample edge only; writes at later edges do not alter a read already in flight.
REQ-032 Read and write ports SHALL be fully independent; there are no stalls and no backpressure.

Reset
REQ-033 While rst=0: r_data_o=0, r_valid_o=0, r_err_o=0, w_err_o=0, and all read pipeline stages are cleared.
REQ-034 Memory contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-035 Reads in flight when reset is asserted SHALL be discarded and never emerge after reset release.
REQ-036 A wen or ren sampled on the first edge after rst deasserts SHALL be honoured normally.

Verification
REQ-037 DW=32, RD_LAT=1: write 0xDEADBEEF to address 0x10 with strobe 0xF, then read 0x10 -> r_valid_o=1 one cycle later, r_data_o=0xDEADBEEF, r_err_o=0.
REQ-038 Write 0x11223344 with strobe 0x5 over word 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-039 Write to 0x12 -> w_err_o pulses one cycle, memory is unchanged; read 0x4000 (AW=12) -> r_err_o=1, r_data_o=0.
REQ-040 Same edge: write 0xCAFEF00D to 0x20 and read 0x20 -> returned data is 0xCAFEF00D.
REQ-041 RD_LAT=2: reads on 4 consecutive edges to 0x0, 0x4, 0x8, 0xC -> 4 consecutive r_valid_o pulses starting 2 cycles after the first request, with data in order.
REQ-042 Assert rst with 2 reads in flight (RD_LAT=2) -> no r_valid_o after release; a read of a previously written word still returns the pre-reset data.
